// File: rtl/fpnew_pipe_stage.sv
// fpnew_pipe_stage: elastic valid/ready register pipeline carrying one FP operation request.
// Optional FPNEW_PIPE_SKID_EN adds a skid register ahead of stage 0 (capacity N+1, registered in_ready_o).
module fpnew_pipe_stage #(
  parameter int unsigned Width       = 64,
  parameter int unsigned NumOperands = 3,
  parameter int unsigned NumPipeRegs = 0,
  parameter int unsigned TagWidth    = 1
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic [NumOperands*Width-1:0] operands_i,
  input  logic [2:0]                   rnd_mode_i,
  input  logic [3:0]                   op_i,
  input  logic                         op_mod_i,
  input  logic [2:0]                   src_fmt_i,
  input  logic [2:0]                   dst_fmt_i,
  input  logic [1:0]                   int_fmt_i,
  input  logic                         vectorial_op_i,
  input  logic [TagWidth-1:0]          tag_i,
  input  logic                         in_valid_i,
  output logic                         in_ready_o,
  input  logic                         flush_i,
  output logic [NumOperands*Width-1:0] operands_o,
  output logic [2:0]                   rnd_mode_o,
  output logic [3:0]                   op_o,
  output logic                         op_mod_o,
  output logic [2:0]                   src_fmt_o,
  output logic [2:0]                   dst_fmt_o,
  output logic [1:0]                   int_fmt_o,
  output logic                         vectorial_op_o,
  output logic [TagWidth-1:0]          tag_o,
  output logic                         out_valid_o,
  input  logic                         out_ready_i,
  output logic                         busy_o
);
  typedef struct packed {
    logic [NumOperands*Width-1:0] operands;
    logic [2:0]                   rnd_mode;
    logic [3:0]                   op;
    logic                         op_mod;
    logic [2:0]                   src_fmt;
    logic [2:0]                   dst_fmt;
    logic [1:0]                   int_fmt;
    logic                         vectorial_op;
    logic [TagWidth-1:0]          tag;
  } req_t;

  req_t w_in_req, w_out_req;

  assign w_in_req = {operands_i, rnd_mode_i, op_i, op_mod_i, src_fmt_i, dst_fmt_i,
                     int_fmt_i, vectorial_op_i, tag_i};
  assign {operands_o, rnd_mode_o, op_o, op_mod_o, src_fmt_o, dst_fmt_o,
          int_fmt_o, vectorial_op_o, tag_o} = w_out_req;

  if (NumPipeRegs == 0) begin : g_pass
    logic w_unused;
    assign w_unused    = clk_i ^ rst_ni ^ flush_i;
    assign w_out_req   = w_in_req;
    assign out_valid_o = in_valid_i;
    assign in_ready_o  = out_ready_i;
    assign busy_o      = 1'b0;
  end else begin : g_pipe
    localparam int unsigned N = NumPipeRegs;

    logic [N-1:0] r_vld;
    req_t         r_data [N];
    logic [N:0]   w_rdy;
    logic [N-1:0] w_up_vld;
    req_t         w_up_data [N];
    logic         w_s0_vld;
    req_t         w_s0_data;

`ifdef FPNEW_PIPE_SKID_EN
    logic r_skid_vld;
    req_t r_skid;

    // A parked request always has priority into stage 0; the input is blocked meanwhile.
    assign w_s0_vld   = r_skid_vld | in_valid_i;
    assign w_s0_data  = r_skid_vld ? r_skid : w_in_req;
    assign in_ready_o = ~r_skid_vld;

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        r_skid_vld <= 1'b0;
        r_skid     <= '0;
      end else if (flush_i) begin
        r_skid_vld <= 1'b0;
      end else if (r_skid_vld) begin
        if (w_rdy[0]) r_skid_vld <= 1'b0;
      end else if (in_valid_i && !w_rdy[0]) begin
        r_skid_vld <= 1'b1;
        r_skid     <= w_in_req;
      end
    end
`else
    assign w_s0_vld   = in_valid_i;
    assign w_s0_data  = w_in_req;
    assign in_ready_o = w_rdy[0] | flush_i;
`endif

    assign w_rdy[N] = out_ready_i;

    for (genvar i = 0; i < N; i++) begin : g_stage
      assign w_rdy[i] = w_rdy[i+1] | ~r_vld[i];
      if (i == 0) begin : g_first
        assign w_up_vld[i]  = w_s0_vld;
        assign w_up_data[i] = w_s0_data;
      end else begin : g_next
        assign w_up_vld[i]  = r_vld[i-1];
        assign w_up_data[i] = r_data[i-1];
      end
    end

    // Data is clock-enabled on real transfers only; flush kills valids but leaves data alone.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        r_vld <= '0;
        for (int i = 0; i < N; i++) r_data[i] <= '0;
      end else begin
        for (int i = 0; i < N; i++) begin
          if (flush_i)       r_vld[i] <= 1'b0;
          else if (w_rdy[i]) r_vld[i] <= w_up_vld[i];
          if (w_rdy[i] && w_up_vld[i]) r_data[i] <= w_up_data[i];
        end
      end
    end

    assign w_out_req   = r_data[N-1];
    assign out_valid_o = r_vld[N-1];
    assign busy_o      = |r_vld;
  end
endmodule
